// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage: MIPS instruction-fetch stage.
// Holds the PC, assembles a little-endian 32-bit word from a byte-array
// instruction memory and loads it into the IF/ID register, honouring stall and
// branch redirect from downstream.
// Optional feature macro: FETCH_NOP_HALT_EN -- halts fetch after NOP_HALT_COUNT
// consecutive all-zero words; without it, halted is tied to 0.
module mips_fetch_stage #(
  parameter int          MEM_BYTES      = 256,
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          NOP_HALT_COUNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  instruction_mem [MEM_BYTES-1:0],
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  output logic [31:0] next_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        misaligned,
  output logic        halted
);

  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic {FETCH = 1'b0, HALT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        misaligned_q, misaligned_d;
  logic [AW-1:0] addr0, addr1, addr2, addr3;
  logic [31:0] word;
`ifdef FETCH_NOP_HALT_EN
  logic [2:0]  nop_cnt_q, nop_cnt_d;
`endif

  // Word assembly: byte addresses wrap modulo MEM_BYTES, highest byte is the MSB.
  always_comb begin
    addr0 = pc_q[AW-1:0];
    addr1 = addr0 + AW'(1);
    addr2 = addr0 + AW'(2);
    addr3 = addr0 + AW'(3);
    word  = {instruction_mem[addr3], instruction_mem[addr2],
             instruction_mem[addr1], instruction_mem[addr0]};
  end

  // Next-state: redirect beats stall beats halted beats normal fetch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    misaligned_d = 1'b0;
`ifdef FETCH_NOP_HALT_EN
    nop_cnt_d    = nop_cnt_q;
`endif
    if (redirect) begin
      pc_d         = {redirect_target[31:2], 2'b00};
      instr_d      = 32'h0;
      valid_d      = 1'b0;
      misaligned_d = |redirect_target[1:0];
      state_d      = FETCH;
`ifdef FETCH_NOP_HALT_EN
      nop_cnt_d    = 3'd0;
`endif
    end else if (stall) begin
      // hold everything; misaligned already defaults low
    end else if (state_q == HALT) begin
      instr_d = 32'h0;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_q + 32'd4;
      instr_d = word;
      pc4_d   = pc_q + 32'd4;
      valid_d = 1'b1;
`ifdef FETCH_NOP_HALT_EN
      if (word != 32'h0) begin
        nop_cnt_d = 3'd0;
      end else if (nop_cnt_q != 3'd7) begin
        nop_cnt_d = nop_cnt_q + 3'd1;
      end
      if (nop_cnt_d >= 3'(NOP_HALT_COUNT)) begin
        state_d = HALT;
      end
`endif
    end
  end

  // State registers; reset dominates every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= 32'h0;
      pc4_q        <= 32'h0;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
`ifdef FETCH_NOP_HALT_EN
      nop_cnt_q    <= 3'd0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      misaligned_q <= misaligned_d;
`ifdef FETCH_NOP_HALT_EN
      nop_cnt_q    <= nop_cnt_d;
`endif
    end
  end

  assign pc               = pc_q;
  assign next_instruction = instr_q;
  assign if_id_pc_plus4   = pc4_q;
  assign if_id_valid      = valid_q;
  assign misaligned       = misaligned_q;
`ifdef FETCH_NOP_HALT_EN
  assign halted           = (state_q == HALT);
`else
  assign halted           = 1'b0;
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// tb_mips_fetch_stage: directed + randomized bench for mips_fetch_stage with a
// behavioural reference model of the fetch rules.
module tb_mips_fetch_stage;
  localparam int          MB   = 256;
  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam int          NHC  = 4;
`ifdef FETCH_NOP_HALT_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_target;
  logic [7:0]  mem [MB-1:0];
  logic [31:0] pc, next_instruction, if_id_pc_plus4;
  logic        if_id_valid, misaligned, halted;

  int n_total = 0;
  int n_pass  = 0;

  // reference model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_mis, m_halt;
  int          m_zeros;

  mips_fetch_stage #(.MEM_BYTES(MB), .RESET_PC(RPC), .NOP_HALT_COUNT(NHC)) dut (
    .clk(clk), .reset(reset), .instruction_mem(mem), .stall(stall),
    .redirect(redirect), .redirect_target(redirect_target), .pc(pc),
    .next_instruction(next_instruction), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .misaligned(misaligned), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mword(input logic [31:0] p);
    int a;
    a = int'(p % MB);
    return {mem[(a + 3) % MB], mem[(a + 2) % MB], mem[(a + 1) % MB], mem[a]};
  endfunction

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_edge(input bit r, input bit st, input bit rd, input logic [31:0] t);
    logic [31:0] w;
    if (r) begin
      m_pc = RPC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_mis = 0; m_halt = 0; m_zeros = 0;
    end else if (rd) begin
      m_pc = t & 32'hFFFF_FFFC; m_instr = 0; m_valid = 0;
      m_mis = (t % 4) != 0; m_halt = 0; m_zeros = 0;
    end else if (st) begin
      m_mis = 0;
    end else if (m_halt) begin
      m_instr = 0; m_valid = 0; m_mis = 0;
    end else begin
      w = mword(m_pc);
      m_instr = w; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4; m_mis = 0;
      if (FEAT) begin
        m_zeros = (w == 0) ? ((m_zeros < 7) ? m_zeros + 1 : 7) : 0;
        if (m_zeros >= NHC) m_halt = 1;
      end
    end
  endtask

  task automatic check_all();
    ck("pc", pc, m_pc);
    ck("instr", next_instruction, m_instr);
    ck("pc_plus4", if_id_pc_plus4, m_pc4);
    ck("valid", {31'h0, if_id_valid}, {31'h0, m_valid});
    ck("misaligned", {31'h0, misaligned}, {31'h0, m_mis});
    ck("halted", {31'h0, halted}, {31'h0, m_halt});
  endtask

  task automatic cyc(input bit r, input bit st, input bit rd, input logic [31:0] t);
    reset = r; stall = st; redirect = rd; redirect_target = t;
    @(posedge clk);
    #1;
    model_edge(r, st, rd, t);
    check_all();
  endtask

  initial begin
    reset = 1; stall = 0; redirect = 0; redirect_target = 0;
    for (int i = 0; i < MB; i++) mem[i] = 8'($urandom);
    mem[3] = 8'h20; mem[2] = 8'h0a; mem[1] = 8'h00; mem[0] = 8'h0a;
    mem[7] = 8'h20; mem[6] = 8'h0c; mem[5] = 8'h00; mem[4] = 8'h0b;
    for (int i = 8; i < 24; i++) mem[i] = 8'h00;
    mem[8'hC8] = 8'h11; mem[8'hC9] = 8'h22; mem[8'hCA] = 8'h33; mem[8'hCB] = 8'h44;

    // reset held two cycles
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    ck("rst_pc", pc, 32'h0);
    ck("rst_valid", {31'h0, if_id_valid}, 32'h0);
    // first fetch
    cyc(0, 0, 0, 0);
    ck("f1_instr", next_instruction, 32'h200a000a);
    ck("f1_pc4", if_id_pc_plus4, 32'h4);
    ck("f1_pc", pc, 32'h4);
    cyc(0, 0, 0, 0);
    ck("f2_instr", next_instruction, 32'h200c000b);
    ck("f2_pc", pc, 32'h8);
    // stall holds
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    ck("stall_pc", pc, 32'h8);
    ck("stall_instr", next_instruction, 32'h200c000b);
    ck("stall_valid", {31'h0, if_id_valid}, 32'h1);
    // redirect beats stall
    cyc(0, 1, 1, 32'h0000_00C8);
    ck("rd_pc", pc, 32'hC8);
    ck("rd_valid", {31'h0, if_id_valid}, 32'h0);
    ck("rd_instr", next_instruction, 32'h0);
    cyc(0, 0, 0, 0);
    ck("c8_instr", next_instruction, 32'h44332211);
    // misaligned target, then memory alias past MEM_BYTES
    cyc(0, 0, 1, 32'h0000_00FE);
    ck("mis_pc", pc, 32'hFC);
    ck("mis_flag", {31'h0, misaligned}, 32'h1);
    cyc(0, 0, 0, 0);
    ck("mis_pulse", {31'h0, misaligned}, 32'h0);
    ck("wrap_pc", pc, 32'h100);
    cyc(0, 0, 0, 0);
    ck("alias_instr", next_instruction, 32'h200a000a);
    ck("alias_pc", pc, 32'h104);
    cyc(0, 0, 0, 0);
    // four zero words
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    ck("nop4_halted", {31'h0, halted}, {31'h0, FEAT});
    ck("nop4_pc", pc, 32'h118);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    ck("halt_pc", pc, FEAT ? 32'h118 : 32'h120);
    ck("halt_valid", {31'h0, if_id_valid}, {31'h0, ~FEAT});
    // redirect resumes
    cyc(0, 0, 1, 32'h0);
    ck("resume_halted", {31'h0, halted}, 32'h0);
    cyc(0, 0, 0, 0);
    ck("resume_instr", next_instruction, 32'h200a000a);
    // 32-bit PC wrap
    cyc(0, 0, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    ck("pcwrap_pc", pc, 32'h0);
    ck("pcwrap_pc4", if_id_pc_plus4, 32'h0);

    // randomized phase
    for (int n = 0; n < 500; n++) begin
      logic [31:0] t;
      bit r, st, rd;
      if ($urandom_range(0, 15) == 0) begin
        int b;
        b = $urandom_range(0, MB / 4 - 1) * 4;
        for (int k = 0; k < 24; k++) mem[(b + k) % MB] = 8'h00;
      end
      if ($urandom_range(0, 31) == 0) mem[$urandom_range(0, MB - 1)] = 8'($urandom);
      r  = ($urandom_range(0, 49) == 0);
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0: t = $urandom;
        1: t = 32'($urandom_range(0, 2 * MB));
        default: t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      endcase
      cyc(r, st, rd, t);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
- Instruction-fetch (IF) stage of the MIPS core; sits directly upstream of decode and feeds the IF/ID pipeline register.
- Holds the PC and assembles a 32-bit word from the byte-array instruction memory.
- Applies stall and branch-redirect control from downstream stages.
- Presents fetched instruction, PC+4 and a valid bit to decode.

Parameters:
- MEM_BYTES, 256, depth of the byte-addressed instruction memory (power of two, >= 4).
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
- NOP_HALT_COUNT, 4, consecutive all-zero words that trigger halt (used only with the optional feature).

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- instruction_mem  in  8 x MEM_BYTES (unpacked [MEM_BYTES-1:0])  instruction bytes.
- stall  in  1  hold PC and IF/ID contents.
- redirect  in  1  taken branch/jump from downstream; load redirect_target.
- redirect_target  in  32  new PC on redirect.
- pc  out  32  current fetch PC.
- next_instruction  out  32  IF/ID instruction register.
- if_id_pc_plus4  out  32  PC+4 of the instruction in IF/ID.
- if_id_valid  out  1  IF/ID holds a real fetched instruction.
- misaligned  out  1  one-cycle pulse: redirect_target[1:0] != 0.
- halted  out  1  fetch halted (tied 0 when the optional feature is absent).

Behaviour:
- Reset (sampled on the clk edge while reset=1, dominates everything):
  - pc=RESET_PC
  - next_instruction=0, if_id_pc_plus4=0, if_id_valid=0
  - misaligned=0, halted=0, NOP counter=0
- Word assembly (combinational), with a = pc mod MEM_BYTES:
  - word = {mem[a+3], mem[a+2], mem[a+1], mem[a]}.
  - Byte indices wrap modulo MEM_BYTES.
  - Byte at the highest address of the group is the MSB (opcode byte).
- Latency: word at pc appears on next_instruction one clk edge later, with if_id_pc_plus4=pc+4 and if_id_valid=1.
- Per-edge priority, outside reset:
  - redirect:
    - pc <= {redirect_target[31:2], 2'b00}
    - IF/ID flushed: next_instruction=0, if_id_valid=0, if_id_pc_plus4 unchanged
    - misaligned <= |redirect_target[1:0]
    - redirect overrides stall and halted (clears halted).
  - else stall: pc and all IF/ID outputs hold; misaligned <= 0.
  - else halted: pc holds; IF/ID loads bubble (0, valid 0).
  - else normal: pc <= pc+4 (32-bit wrap, FFFF_FFFC -> 0); IF/ID loads word.
- Memory wrap: a PC at or beyond MEM_BYTES reads the aliased address (pc mod MEM_BYTES). Not an error.
- State machine, two states:
  - FETCH -> HALT when the halt condition fires (optional feature only).
  - HALT -> FETCH on redirect.
  - Reset -> FETCH.
- A word of 0 is a legal NOP: if_id_valid=1, next_instruction=0.

Optional Feature:
- Macro: FETCH_NOP_HALT_EN.
- With the macro defined:
  - A 3-bit saturating counter increments on each normal-path load of word==0.
  - Any non-zero word load resets it; stall holds it; redirect and reset clear it.
  - When the counter reaches NOP_HALT_COUNT, halted <= 1 on that same edge and the state moves to HALT.
  - halted stays 1 until redirect or reset.
- Without the macro: no counter, halted is constant 0, HALT state never entered.

Test Plan:
- Reset behaviour: mem[3:0]={20,0a,00,0a}; hold reset 2 cycles, release -> after 1st edge next_instruction=200a000a, if_id_pc_plus4=4, if_id_valid=1, pc=4.
- Sequential fetch: second word {20,0c,00,0b} at 7:4 -> next edge next_instruction=200c000b, pc=8; pc advances by 4 per edge.
- Stall and redirect: stall=1 for 3 cycles at pc=8 -> pc, next_instruction and if_id_valid hold. Then redirect=1 with target=0xC8 together with stall=1 -> pc=C8, if_id_valid=0, next_instruction=0. Next edge fetches mem[CB:C8].
- Misaligned target and wrap: redirect_target=0x0000_00FE -> pc=FC, misaligned=1 for one cycle. Next edge pc=0x100 reads mem[3:0] (aliased), pc=0x104 after that.
- NOP halt (FETCH_NOP_HALT_EN): four consecutive zero words after two non-zero words -> halted=1 on the edge loading the 4th zero; pc frozen; if_id_valid=0 thereafter. A redirect to 0 clears halted and fetch resumes at 200a000a.
- Without the macro, same stimulus -> halted stays 0, pc keeps incrementing through zeros.
